rv32_button_reg: RTL and testbench

MMIO input peripheral on the PicoRV32 native bus: the read-direction counterpart to the seven-segment output register. It synchronizes and debounces up to 32 board inputs (buttons/switches) and exposes them to the CPU as two words. Word 0 holds the current debounced levels. Word 1 holds sticky rising-edge event flags, which software clears by writing 1s.

---
 rtl/rv32_button_reg_if.sv | 20 ++
 rtl/rv32_button_reg.sv | 130 +++++++++++++
 tb/tb_rv32_button_reg.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rv32_button_reg_if.sv
// PicoRV32 native-bus signal bundle for the button register block.
// The CPU side uses master; the peripheral uses slave.
interface rv32_button_reg_if;
  logic        rv32_valid;
  logic        rv32_ready;
  logic [31:0] rv32_addr;
  logic [31:0] rv32_wdata;
  logic [3:0]  rv32_wstrb;
  logic [31:0] rv32_rdata;

  modport master (
    output rv32_valid, rv32_addr, rv32_wdata, rv32_wstrb,
    input  rv32_ready, rv32_rdata
  );

  modport slave (
    input  rv32_valid, rv32_addr, rv32_wdata, rv32_wstrb,
    output rv32_ready, rv32_rdata
  );
endinterface

// File: rtl/rv32_button_reg.sv
// Debounced button/switch input peripheral on the PicoRV32 native bus.
//   addr[2] = 0 : LEVEL  (read-only, debounced levels)
//   addr[2] = 1 : EVENTS (sticky rising-edge flags, write 1 to clear)

// One input: 2-flop synchronizer, debounce counter, sticky rise flag.
module rv32_button_lane #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic clr,
  output logic level,
  output logic flag
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic          s;

  assign s = sync_q[1];

  // Next-state: a new level must persist DEBOUNCE_CYCLES samples; any
  // reversion zeroes the count. A rise sets the flag and wins over clear.
  always_comb begin
    sync_d  = {sync_q[0], pin};
    level_d = level_q;
    cnt_d   = cnt_q;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    flag_d = (flag_q & ~clr) | (level_d & ~level_q);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  assign level = level_q;
  assign flag  = flag_q;
endmodule

module rv32_button_reg #(
  parameter int INPUTS          = 8,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  rv32_button_reg_if.slave      bus,
  input  logic [INPUTS-1:0]     buttons_in,
  output logic [INPUTS-1:0]     buttons_level
);
  logic [INPUTS-1:0] levels;
  logic [INPUTS-1:0] flags;
  logic [INPUTS-1:0] clr;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              take;
  logic              is_write;
  logic              wr_events;
  logic              unused_bus_bits;

  // Only addr[2] and the low INPUTS data bits matter.
  assign unused_bus_bits = ^{bus.rv32_addr, bus.rv32_wdata};

  // A request is taken only when ready is low, so a held valid produces
  // one transaction per two cycles and never a double-count.
  assign take      = bus.rv32_valid & ~ready_q;
  assign is_write  = |bus.rv32_wstrb;
  assign wr_events = take & is_write & bus.rv32_addr[2];

  // W1C mask: a data bit clears only if its byte lane is strobed.
  for (genvar i = 0; i < INPUTS; i++) begin : g_clr
    assign clr[i] = wr_events & bus.rv32_wdata[i] & bus.rv32_wstrb[i/8];
  end

  rv32_button_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_lane [INPUTS-1:0] (
    .clk   (clk),
    .rst   (rst),
    .pin   (buttons_in),
    .clr   (clr),
    .level (levels),
    .flag  (flags)
  );

  // Bus response: reads sample pre-edge state; writes leave rdata alone.
  always_comb begin
    ready_d = take;
    rdata_d = rdata_q;
    if (take && !is_write)
      rdata_d = bus.rv32_addr[2] ? 32'(flags) : 32'(levels);
  end

  // Bus response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.rv32_ready = ready_q;
  assign bus.rv32_rdata = rdata_q;
  assign buttons_level  = levels;
endmodule

// File: tb/tb_rv32_button_reg.sv
// Directed bench for rv32_button_reg with a short debounce window.
module tb_rv32_button_reg;
  localparam int INPUTS = 8;
  localparam int DB     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [INPUTS-1:0] buttons_in = '0;
  logic [INPUTS-1:0] buttons_level;
  int                errors = 0;
  int                checks = 0;

  rv32_button_reg_if bus();

  rv32_button_reg #(.INPUTS(INPUTS), .DEBOUNCE_CYCLES(DB)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .buttons_in    (buttons_in),
    .buttons_level (buttons_level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.rv32_valid = 1'b0;
    bus.rv32_wstrb = '0;
    buttons_in = '0;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One request; returns ready/rdata seen after the first edge, then idles a cycle.
  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          output logic rdy, output logic [31:0] rd);
    bus.rv32_valid = 1'b1;
    bus.rv32_addr  = a;
    bus.rv32_wdata = wd;
    bus.rv32_wstrb = ws;
    tick(1);
    rdy = bus.rv32_ready;
    rd  = bus.rv32_rdata;
    bus.rv32_valid = 1'b0;
    bus.rv32_wstrb = '0;
    tick(1);
  endtask

  task automatic test_reset();
    logic rdy; logic [31:0] rd;
    rst = 1'b1; bus.rv32_valid = 1'b0; bus.rv32_addr = '0; bus.rv32_wdata = '0;
    bus.rv32_wstrb = '0; buttons_in = '0;
    #13;
    checks++; if (buttons_level !== 8'h00) begin errors++; $display("FAIL reset_level: got %h want 00", buttons_level); end
    checks++; if (bus.rv32_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.rv32_ready); end
    checks++; if (bus.rv32_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rv32_rdata); end
    @(posedge clk); #1; rst = 1'b0;
    tick(1);
    bus_xfer(32'h0, 32'h0, 4'h0, rdy, rd);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_read_ready: got %b want 1", rdy); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_read_level: got %h want 00000000", rd); end
    checks++; if (bus.rv32_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_pulse: got %b want 0", bus.rv32_ready); end
  endtask

  task automatic test_debounce();
    logic rdy; logic [31:0] rd;
    apply_reset();
    buttons_in[0] = 1'b1;
    tick(5);
    checks++; if (buttons_level !== 8'h00) begin errors++; $display("FAIL deb_edge5: got %h want 00", buttons_level); end
    tick(1);
    checks++; if (buttons_level !== 8'h01) begin errors++; $display("FAIL deb_edge6: got %h want 01", buttons_level); end
    bus_xfer(32'h4, 32'h0, 4'h0, rdy, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL deb_events: got %h want 00000001", rd); end
    bus_xfer(32'h0, 32'h0, 4'h0, rdy, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL deb_level: got %h want 00000001", rd); end
  endtask

  task automatic test_glitch();
    logic rdy; logic [31:0] rd;
    apply_reset();
    buttons_in[3] = 1'b1; tick(3); buttons_in[3] = 1'b0;
    tick(8);
    checks++; if (buttons_level !== 8'h00) begin errors++; $display("FAIL glitch3_level: got %h want 00", buttons_level); end
    bus_xfer(32'h4, 32'h0, 4'h0, rdy, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL glitch3_events: got %h want 00000000", rd); end
    buttons_in[3] = 1'b1; tick(4); buttons_in[3] = 1'b0;
    tick(2);
    checks++; if (buttons_level !== 8'h08) begin errors++; $display("FAIL pulse4_rise: got %h want 08", buttons_level); end
    tick(3);
    checks++; if (buttons_level !== 8'h08) begin errors++; $display("FAIL pulse4_hold: got %h want 08", buttons_level); end
    tick(1);
    checks++; if (buttons_level !== 8'h00) begin errors++; $display("FAIL pulse4_fall: got %h want 00", buttons_level); end
    bus_xfer(32'h4, 32'h0, 4'h0, rdy, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL pulse4_events: got %h want 00000008", rd); end
  endtask

  task automatic test_w1c();
    logic rdy; logic [31:0] rd;
    apply_reset();
    buttons_in = 8'h81; tick(8);
    bus_xfer(32'h4, 32'h0, 4'h0, rdy, rd);
    checks++; if (rd !== 32'h81) begin errors++; $display("FAIL w1c_set: got %h want 00000081", rd); end
    bus_xfer(32'h4, 32'hFF, 4'b0001, rdy, rd);
    checks++; if (rd !== 32'h81) begin errors++; $display("FAIL w1c_rdata_hold: got %h want 00000081", rd); end
    bus_xfer(32'h4, 32'h0, 4'h0, rdy, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_clear: got %h want 00000000", rd); end
    buttons_in = 8'h00; tick(8);
    buttons_in = 8'h01; tick(8);
    bus_xfer(32'h4, 32'hFF, 4'b0010, rdy, rd);
    bus_xfer(32'h4, 32'h0, 4'h0, rdy, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL w1c_wrong_lane: got %h want 00000001", rd); end
    bus_xfer(32'h0, 32'hFF, 4'hF, rdy, rd);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL level_write_ack: got %b want 1", rdy); end
    bus_xfer(32'h0, 32'h0, 4'h0, rdy, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL level_write_ignored: got %h want 00000001", rd); end
  endtask

  task automatic test_set_wins();
    logic rdy; logic [31:0] rd;
    apply_reset();
    buttons_in[2] = 1'b1;
    tick(5);
    // Write is taken on the 6th edge, the same edge the level rises.
    bus_xfer(32'h4, 32'h04, 4'b0001, rdy, rd);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL setwins_ack: got %b want 1", rdy); end
    checks++; if (buttons_level !== 8'h04) begin errors++; $display("FAIL setwins_level: got %h want 04", buttons_level); end
    bus_xfer(32'h4, 32'h0, 4'h0, rdy, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL setwins_events: got %h want 00000004", rd); end
  endtask

  task automatic test_back_to_back();
    logic rdy; logic [31:0] rd;
    logic [3:0] rdy_seq;
    apply_reset();
    buttons_in = 8'h10; tick(8);
    bus.rv32_valid = 1'b1; bus.rv32_addr = 32'h0; bus.rv32_wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      rdy_seq[i] = bus.rv32_ready;
      if (i == 0) begin
        checks++; if (bus.rv32_rdata !== 32'h10) begin errors++; $display("FAIL b2b_rdata: got %h want 00000010", bus.rv32_rdata); end
      end
    end
    bus.rv32_valid = 1'b0;
    checks++; if (rdy_seq !== 4'b0101) begin errors++; $display("FAIL b2b_ready_seq: got %b want 0101", rdy_seq); end
    tick(1);
    bus.rv32_valid = 1'b1;
    tick(1);
    checks++; if (bus.rv32_ready !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", bus.rv32_ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.rv32_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", bus.rv32_ready); end
    checks++; if (buttons_level !== 8'h00) begin errors++; $display("FAIL rstmid_level: got %h want 00", buttons_level); end
    checks++; if (bus.rv32_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h want 0", bus.rv32_rdata); end
    bus.rv32_valid = 1'b0; buttons_in = '0;
    @(posedge clk); #1; rst = 1'b0;
    bus_xfer(32'h4, 32'h0, 4'h0, rdy, rd);
    checks++; if (rd !== 32'h0 || rdy !== 1'b1) begin errors++; $display("FAIL rstmid_events: got %h/%b want 00000000/1", rd, rdy); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_w1c();
    test_set_wins();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
